// File: rtl/shift_scheduler.sv
// Two-requester barrel-free shift engine: arbitrates round-robin, shifts up to
// MAX_STEP bits per cycle, and returns the result plus a sticky lost-bit flag.
module shift_scheduler #(
  parameter int WORD_LENGTH = 8,
  parameter int STEP_WIDTH  = 8,
  parameter int MAX_STEP    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               req_valid,
  output logic [1:0]               req_ready,
  input  logic [2*WORD_LENGTH-1:0] req_data,
  input  logic [1:0]               req_dir,
  input  logic [2*STEP_WIDTH-1:0]  req_steps,
  input  logic [1:0]               req_sign,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_id,
  output logic [WORD_LENGTH-1:0]   rsp_data,
  output logic                     rsp_lost,
  output logic                     busy
);

  localparam int REM_W = $clog2(WORD_LENGTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                 state, state_next;
  logic                   last_grant;
  logic                   id_q, dir_q, sign_q, lost_q, valid_q;
  logic [WORD_LENGTH-1:0] data_q;
  logic [REM_W-1:0]       remaining;

  logic                   grant_id, accept;
  logic [WORD_LENGTH-1:0] sel_data, shift_data;
  logic [STEP_WIDTH-1:0]  sel_steps;
  logic [REM_W-1:0]       rem_init, amt;
  logic                   shift_lost;

  // Arbitration: a lone requester wins outright, a tie goes to the one not served last.
  always_comb begin
    grant_id = 1'b0;
    if (req_valid == 2'b10)
      grant_id = 1'b1;
    else if (req_valid == 2'b11)
      grant_id = ~last_grant;
    accept    = reset && (state == IDLE) && (|req_valid);
    req_ready = 2'b00;
    if (accept)
      req_ready[grant_id] = 1'b1;
    sel_data  = grant_id ? req_data[2*WORD_LENGTH-1:WORD_LENGTH] : req_data[WORD_LENGTH-1:0];
    sel_steps = grant_id ? req_steps[2*STEP_WIDTH-1:STEP_WIDTH] : req_steps[STEP_WIDTH-1:0];
    if (32'(sel_steps) > 32'(WORD_LENGTH))
      rem_init = REM_W'(WORD_LENGTH);
    else
      rem_init = REM_W'(sel_steps);
  end

  // One-bit steps repeated amt times keep the lost-bit OR exact for any amount.
  always_comb begin
    amt        = (remaining > REM_W'(MAX_STEP)) ? REM_W'(MAX_STEP) : remaining;
    shift_data = data_q;
    shift_lost = lost_q;
    for (int i = 0; i < MAX_STEP; i++) begin
      if (REM_W'(i) < amt) begin
        if (dir_q) begin
          shift_lost = shift_lost | shift_data[WORD_LENGTH-1];
          shift_data = shift_data << 1;
        end else begin
          shift_lost = shift_lost | shift_data[0];
          shift_data = shift_data >> 1;
          shift_data[WORD_LENGTH-1] = sign_q;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (rem_init == '0) ? DONE : SHIFT;
      SHIFT:   if (remaining == amt) state_next = DONE;
      DONE:    if (valid_q && rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // rsp_valid is registered, so it rises one cycle after DONE is entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      dir_q      <= 1'b0;
      sign_q     <= 1'b0;
      lost_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      remaining  <= '0;
    end else begin
      state   <= state_next;
      valid_q <= (state == DONE) && !(valid_q && rsp_ready);
      case (state)
        IDLE: if (accept) begin
          data_q     <= sel_data;
          dir_q      <= req_dir[grant_id];
          sign_q     <= req_sign[grant_id];
          id_q       <= grant_id;
          last_grant <= grant_id;
          remaining  <= rem_init;
          lost_q     <= 1'b0;
        end
        SHIFT: begin
          data_q    <= shift_data;
          lost_q    <= shift_lost;
          remaining <= remaining - amt;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = valid_q && reset;
  assign busy      = (state != IDLE) && reset;
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;
  assign rsp_lost  = lost_q;

endmodule

// File: doc/shift_scheduler.md
SHIFT_SCHEDULER -- requirements
Module: shift_scheduler

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 8: operand/result width.
REQ-002 SHALL have parameter STEP_WIDTH, default 8: width of each requester's shift-count field.
REQ-003 SHALL have parameter MAX_STEP, default 4: maximum bit positions shifted per cycle, range 1..WORD_LENGTH.
REQ-004 SHALL have port clk, input, 1: rising-edge clock.
REQ-005 SHALL have port reset, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port req_valid, input, 2: per-requester request valid; bit i belongs to requester i.
REQ-007 SHALL have port req_ready, output, 2: per-requester accept strobe.
REQ-008 SHALL have port req_data, input, 2*WORD_LENGTH: operands; requester i uses slice [i*WORD_LENGTH +: WORD_LENGTH].
REQ-009 SHALL have port req_dir, input, 2: per-requester direction; 1 = left, 0 = right.
REQ-010 SHALL have port req_steps, input, 2*STEP_WIDTH: per-requester shift counts, sliced as req_data.
REQ-011 SHALL have port req_sign, input, 2: per-requester fill bit for right shifts.
REQ-012 SHALL have port rsp_valid, output, 1: result available.
REQ-013 SHALL have port rsp_ready, input, 1: result consumer ready.
REQ-014 SHALL have port rsp_id, output, 1: index of the requester that owns the result.
REQ-015 SHALL have port rsp_data, output, WORD_LENGTH: shifted result.
REQ-016 SHALL have port rsp_lost, output, 1: OR of every bit shifted out of the word.
REQ-017 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, SHIFT and DONE, with one job in flight at most.
REQ-019 In IDLE with any req_valid set, SHALL grant one requester and assert only that requester's req_ready bit for that cycle; req_ready SHALL be 2'b00 in SHIFT and DONE.
REQ-020 With exactly one req_valid bit set, SHALL grant that requester.
REQ-021 With both bits set, SHALL grant the requester not granted last (round-robin); the last-grant pointer SHALL reset to 1, so requester 0 wins the first tie.
REQ-022 On the accept edge, SHALL capture data, dir, sign, id and remaining = min(steps, WORD_LENGTH), and SHALL clear lost.
REQ-023 Clamping to WORD_LENGTH SHALL be result-exact: left gives 0; right gives all fill bits; lost is the OR of all original bits.
REQ-024 After accept, SHALL go to DONE if remaining == 0; otherwise it SHALL go to SHIFT.
REQ-025 In SHIFT, each cycle SHALL shift by amt = min(remaining, MAX_STEP) and SHALL set remaining = remaining - amt.
  - Left shift: zeros enter at bit 0.
  - Right shift: the captured sign bit enters at the MSB.
  - lost |= OR of the amt bits leaving the word.
REQ-026 SHALL go from SHIFT to DONE on the cycle remaining reaches 0.
REQ-027 Latency: with accept at edge T, rsp_valid SHALL rise after edge T+1+ceil(min(steps,WORD_LENGTH)/MAX_STEP); for steps == 0, it SHALL rise after edge T+1.
REQ-028 In DONE, SHALL assert rsp_valid and hold rsp_id, rsp_data and rsp_lost stable until rsp_valid && rsp_ready.
REQ-029 On the response handshake, SHALL return to IDLE; a new request SHALL NOT be accepted in the handshake cycle.
REQ-030 rsp_valid SHALL be 0 outside DONE.
REQ-031 Requesters SHALL hold their request until their req_ready is seen; an unaccepted request SHALL NOT change arbitration state.

Reset
REQ-032 With reset low at a clock edge, SHALL force state IDLE, last-grant pointer = 1, and remaining and internal data/lost registers to 0, from any state including mid-SHIFT.
REQ-033 During and after reset, SHALL drive rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_lost = 0, busy = 0 and req_ready = 0.

Verification
REQ-034 Bench SHALL cover (WORD_LENGTH=8, MAX_STEP=4):
  - Req0: data 0xB4, right, steps 3, sign 1 -> rsp 0xF6, lost 1, id 0, rsp_valid after edge T+2.
  - Req1: data 0x81, left, steps 9 (clamped to 8) -> rsp 0x00, lost 1, id 1, rsp_valid after edge T+3.
  - Data 0x5A, steps 0 -> rsp 0x5A, lost 0, rsp_valid after edge T+1. Separately: data 0x0F, right, steps 6, sign 0 -> two SHIFT cycles, rsp 0x00, lost 1.
  - Both req_valid high continuously from reset -> grants 0,1,0,1; rsp_id alternates; each grant is a single-cycle req_ready pulse.
  - rsp_ready low 3 cycles in DONE -> rsp fields stable, busy 1, req_ready 0; rsp_ready high -> IDLE next cycle.
  - reset low mid-SHIFT -> next cycle rsp_valid 0, busy 0, and a subsequent tie is granted to requester 0.
